// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO owner: mult/div results land after a fixed busy window, move-to/from HI/LO act immediately.
// Latency MULT_CYCLES or DIV_CYCLES edges; stall holds md-dependent decode while busy or while an md op starts.
module mult_div_unit #(
   parameter int ALU_OP_LEN  = 5,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MULT  = ALU_OP_LEN'(16),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MULTU = ALU_OP_LEN'(17),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_DIV   = ALU_OP_LEN'(18),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_DIVU  = ALU_OP_LEN'(19),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MFLO  = ALU_OP_LEN'(20),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MFHI  = ALU_OP_LEN'(21),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MTLO  = ALU_OP_LEN'(22),
   parameter logic [ALU_OP_LEN-1:0] ALU_OP_MTHI  = ALU_OP_LEN'(23)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ALU_OP_LEN-1:0] op,
   input  logic [31:0]           src0,
   input  logic [31:0]           src1,
   input  logic                  decode_uses_md,
   output logic                  busy,
   output logic                  stall,
   output logic [31:0]           hi,
   output logic [31:0]           lo,
   output logic [31:0]           result
);

   localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   logic [CW-1:0] count;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_valid;

   logic          accept;
   logic          is_md_calc;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   div_den;
   logic          div_ovf;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic [31:0]   q_u;
   logic [31:0]   r_u;

   assign busy   = (count != '0);
   assign accept = start && !busy;

   assign is_md_calc = (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
                       (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
   assign stall = decode_uses_md && (busy || (start && is_md_calc));

   assign prod_s = {{32{src0[31]}}, src0} * {{32{src1[31]}}, src1};
   assign prod_u = {32'd0, src0} * {32'd0, src1};

   // A zero divisor is replaced so the divider never sees it; its result is discarded anyway.
   assign div_den = (src1 == 32'd0) ? 32'd1 : src1;
   assign div_ovf = (src0 == 32'h8000_0000) && (src1 == 32'hFFFF_FFFF);
   assign sa      = src0;
   assign sb      = div_den;

   always_comb begin
      q_s = sa / sb;
      r_s = sa % sb;
      if (div_ovf) begin
         q_s = 32'sh8000_0000;
         r_s = 32'sd0;
      end
   end

   assign q_u = src0 / div_den;
   assign r_u = src0 % div_den;

   always_comb begin
      result = 32'd0;
      if (op == ALU_OP_MFLO)
         result = lo;
      else if (op == ALU_OP_MFHI)
         result = hi;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi         <= 32'd0;
         lo         <= 32'd0;
         count      <= '0;
         pend_hi    <= 32'd0;
         pend_lo    <= 32'd0;
         pend_valid <= 1'b0;
      end else if (busy) begin
         count <= count - CW'(1);
         if (count == CW'(1)) begin
            if (pend_valid) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
            pend_valid <= 1'b0;
         end
      end else if (accept) begin
         case (op)
            ALU_OP_MULT: begin
               {pend_hi, pend_lo} <= prod_s;
               pend_valid         <= 1'b1;
               count              <= CW'(MULT_CYCLES);
            end
            ALU_OP_MULTU: begin
               {pend_hi, pend_lo} <= prod_u;
               pend_valid         <= 1'b1;
               count              <= CW'(MULT_CYCLES);
            end
            ALU_OP_DIV: begin
               pend_hi    <= r_s;
               pend_lo    <= q_s;
               pend_valid <= (src1 != 32'd0);
               count      <= CW'(DIV_CYCLES);
            end
            ALU_OP_DIVU: begin
               pend_hi    <= r_u;
               pend_lo    <= q_u;
               pend_valid <= (src1 != 32'd0);
               count      <= CW'(DIV_CYCLES);
            end
            ALU_OP_MTLO: lo <= src0;
            ALU_OP_MTHI: hi <= src0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, compared when busy drops.
module tb_mult_div_unit;

   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_MULT  = 5'd16;
   localparam logic [4:0] OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV   = 5'd18;
   localparam logic [4:0] OP_DIVU  = 5'd19;
   localparam logic [4:0] OP_MFLO  = 5'd20;
   localparam logic [4:0] OP_MFHI  = 5'd21;
   localparam logic [4:0] OP_MTLO  = 5'd22;
   localparam logic [4:0] OP_MTHI  = 5'd23;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [4:0]  op;
   logic [31:0] src0;
   logic [31:0] src1;
   logic        decode_uses_md;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   logic [63:0] sb_q[$];
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   mult_div_unit dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .src0(src0), .src1(src1), .decode_uses_md(decode_uses_md),
      .busy(busy), .stall(stall), .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Issue one md op, count busy cycles, then pop and compare the scoreboard entry.
   task automatic run_md(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic dum, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic poke);
      int n;
      logic [63:0] e;
      decode_uses_md = dum;
      start = 1'b1; op = o; src0 = a; src1 = b;
      #1;
      chk("stall_start", stall, dum);
      sb_q.push_back({exp_hi, exp_lo});
      @(posedge clk); #1;
      start = 1'b0; op = OP_NOP;
      #1;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         chk("stall_busy", stall, dum);
         n++;
         if (poke && n == 2) begin
            start = 1'b1; op = OP_MTHI; src0 = 32'hDEAD_BEEF;
         end
         @(posedge clk); #1;
         start = 1'b0; op = OP_NOP;
         #1;
      end
      chk("busy_len", n, exp_cyc);
      e = sb_q.pop_front();
      model_hi = e[63:32];
      model_lo = e[31:0];
      chk("hi", hi, model_hi);
      chk("lo", lo, model_lo);
      op = OP_MFLO; #1;
      chk("mflo_after", result, model_lo);
      op = OP_MFHI; #1;
      chk("mfhi_after", result, model_hi);
      op = OP_NOP;
   endtask

   initial begin
      logic [31:0] a, b;
      logic [63:0] p;
      reset_n = 1'b0; start = 1'b0; op = OP_NOP; src0 = '0; src1 = '0; decode_uses_md = 1'b1;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      op = OP_MFHI; #1;
      chk("rst_result", result, 0);
      op = OP_NOP;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_md(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 5,  32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      // Divide by zero keeps HI/LO; an mthi arriving while busy must be ignored too.
      run_md(OP_DIVU,  32'd7, 32'd0, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
      run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0, 32'h8000_0000, 1'b0);
      run_md(OP_DIV,   32'd7, 32'hFFFF_FFFE, 1'b0, 10, 32'h1, 32'hFFFF_FFFD, 1'b0);
      run_md(OP_DIV,   32'd5, 32'd0, 1'b0, 10, 32'h1, 32'hFFFF_FFFD, 1'b0);

      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom;
         p = {32'd0, a} * {32'd0, b};
         run_md(OP_MULTU, a, b, 1'b1, 5, p[63:32], p[31:0], 1'b0);
         p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         run_md(OP_MULT, a, b, 1'b0, 5, p[63:32], p[31:0], 1'b0);
         b = $urandom_range(1, 1000);
         run_md(OP_DIVU, a, b, 1'b1, 10, a % b, a / b, 1'b0);
      end

      start = 1'b1; op = OP_MTHI; src0 = 32'h1234_5678; decode_uses_md = 1'b1;
      #1;
      chk("stall_mthi", stall, 0);
      @(posedge clk); #1;
      start = 1'b1; op = OP_MFHI; #1;
      chk("mfhi_mthi", result, 32'h1234_5678);
      chk("busy_mthi", busy, 0);
      op = OP_MTLO; src0 = 32'hCAFE_F00D;
      @(posedge clk); #1;
      start = 1'b0; op = OP_MFLO; #1;
      chk("mflo_mtlo", result, 32'hCAFE_F00D);
      chk("hi_kept", hi, 32'h1234_5678);

      op = OP_DIV; src0 = 32'd100; src1 = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NOP;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("busy_pre_rst", busy, 1);
      reset_n = 1'b0; #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_stall", stall, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_hi", hi, 0);
      chk("post_rst_lo", lo, 0);
      chk("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
